// File: rtl/tx_pkg.sv
// ----------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the transmit serializer / FFE driver:
//   tx_state_e  - serializer FSM states (IDLE, SHIFT)
//   SYM_IDLE    - symbol value driven during electrical idle
//   DEF_C_*     - default FFE tap coefficients
//   bit_to_sym  - antipodal mapping of a data bit to +/-1.0
// ----------------------------------------------------------------------------
package tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  localparam real SYM_IDLE   = 0.0;
  localparam real DEF_C_PRE  = -0.1;
  localparam real DEF_C_MAIN = 0.7;
  localparam real DEF_C_POST = -0.2;

  function automatic real bit_to_sym(input logic b);
    return b ? 1.0 : -1.0;
  endfunction

endpackage

// File: rtl/tx_ffe_fir.sv
// ----------------------------------------------------------------------------
// tx_ffe_fir
// Three-symbol delay line (pre -> main -> post) plus the tap combiner that
// forms the pre-emphasized line value.
// Ports:
//   clk      - bit-rate clock, pipe advances on every posedge
//   rst      - asynchronous active-high reset, clears all symbols to idle
//   sym_in   - next symbol entering the pre-cursor slot (+1.0, -1.0 or 0.0)
//   ffe_out  - V_SWING * (C_PRE*pre + C_MAIN*main + C_POST*post)
//   sym_main - symbol currently at the main cursor
// ----------------------------------------------------------------------------
module tx_ffe_fir
  import tx_pkg::*;
#(
  parameter real C_PRE   = DEF_C_PRE,
  parameter real C_MAIN  = DEF_C_MAIN,
  parameter real C_POST  = DEF_C_POST,
  parameter real V_SWING = 1.0
) (
  input  logic clk,
  input  logic rst,
  input  real  sym_in,
  output real  ffe_out,
  output real  sym_main
);

  real sym_pre;
  real main_q;
  real sym_post;

  // NOTE: sequential state uses non-blocking assignments so every stage of the
  // pipe samples its predecessor's value from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_pre  <= SYM_IDLE;
      main_q   <= SYM_IDLE;
      sym_post <= SYM_IDLE;
    end else begin
      sym_pre  <= sym_in;
      main_q   <= sym_pre;
      sym_post <= main_q;
    end
  end

  // Purely combinational from the registers, so reset zeroes the line at once.
  always_comb begin
    ffe_out = V_SWING * (C_PRE * sym_pre + C_MAIN * main_q + C_POST * sym_post);
  end

  assign sym_main = main_q;

endmodule

// File: rtl/tx_ffe_serializer.sv
// ----------------------------------------------------------------------------
// tx_ffe_serializer
// Accepts parallel words over valid/ready, shifts them out LSB-first at the
// bit clock as antipodal symbols, and drives a 3-tap FFE line waveform.
// Back-to-back words stream without gaps: the next word is taken on the same
// edge that launches the last bit of the current one.
// Ports:
//   clk        - bit-rate clock
//   rst        - asynchronous active-high reset
//   data_in    - parallel word, bit 0 transmitted first
//   data_valid - data_in is valid
//   data_ready - a word can be accepted this cycle (combinational)
//   ffe_out    - pre-emphasized line value
//   bit_out    - data bit at the main cursor
//   tx_active  - a data symbol (not idle) is at the main cursor
// ----------------------------------------------------------------------------
module tx_ffe_serializer
  import tx_pkg::*;
#(
  parameter int  WIDTH   = 10,
  parameter real C_PRE   = DEF_C_PRE,
  parameter real C_MAIN  = DEF_C_MAIN,
  parameter real C_POST  = DEF_C_POST,
  parameter real V_SWING = 1.0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output real              ffe_out,
  output logic             bit_out,
  output logic             tx_active
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  tx_state_e        state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  real              sym_next;
  real              sym_main;

  // Ready is forced low during reset; in SHIFT it opens only on the last bit,
  // which is what makes reload-on-the-same-edge gapless.
  assign data_ready = !rst && ((state == IDLE) || (cnt == LAST));
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else if (accept) begin
      shreg <= data_in;
      cnt   <= '0;
      state <= SHIFT;
    end else if (state == SHIFT) begin
      if (cnt == LAST) begin
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Symbol entering the pre-cursor slot; idle flushes 0.0 through the pipe.
  always_comb begin
    sym_next = SYM_IDLE;
    if (state == SHIFT) begin
      sym_next = bit_to_sym(shreg[cnt]);
    end
  end

  tx_ffe_fir #(
    .C_PRE  (C_PRE),
    .C_MAIN (C_MAIN),
    .C_POST (C_POST),
    .V_SWING(V_SWING)
  ) u_fir (
    .clk     (clk),
    .rst     (rst),
    .sym_in  (sym_next),
    .ffe_out (ffe_out),
    .sym_main(sym_main)
  );

  assign bit_out   = (sym_main > 0.0);
  assign tx_active = (sym_main != 0.0);

endmodule

// File: tb/tb_tx_ffe_serializer.sv
// ----------------------------------------------------------------------------
// tb_tx_ffe_serializer
// Directed bench for tx_ffe_serializer: default-tap instance for the main
// scenarios, plus a second instance with only the main tap and half swing.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_tx_ffe_serializer;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  real          ffe_out;
  logic         bit_out;
  logic         tx_active;

  logic [W-1:0] data_in2;
  logic         data_valid2;
  logic         data_ready2;
  real          ffe_out2;
  logic         bit_out2;
  logic         tx_active2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tx_ffe_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .ffe_out   (ffe_out),
    .bit_out   (bit_out),
    .tx_active (tx_active)
  );

  tx_ffe_serializer #(
    .WIDTH  (W),
    .C_PRE  (0.0),
    .C_POST (0.0),
    .V_SWING(0.5)
  ) dut_main_only (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in2),
    .data_valid(data_valid2),
    .data_ready(data_ready2),
    .ffe_out   (ffe_out2),
    .bit_out   (bit_out2),
    .tx_active (tx_active2)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    checks++;
    assert (((obs - exp) < 1.0e-9) && ((exp - obs) < 1.0e-9)) else begin
      errors++;
      $error("FAIL %s: observed=%0.4f expected=%0.4f", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Hand-derived line values for word 10'h001, after edges k+2 .. k+13.
  real exp_single [12] = '{0.8, -0.8, -0.4, -0.4, -0.4, -0.4, -0.4, -0.4,
                           -0.4, -0.5, 0.2, 0.0};

  logic [2*W-1:0] stream;
  logic [W-1:0]   word;

  initial begin
    rst         = 1'b1;
    data_in     = '0;
    data_valid  = 1'b0;
    data_in2    = '0;
    data_valid2 = 1'b0;

    // ---- reset state ------------------------------------------------------
    tick();
    chk_b("rst_ready", data_ready, 1'b0);
    chk_r("rst_ffe", ffe_out, 0.0);
    chk_b("rst_active", tx_active, 1'b0);
    rst = 1'b0;
    #1;
    chk_b("idle_ready", data_ready, 1'b1);
    tick();

    // ---- single word 10'h001 ----------------------------------------------
    data_in    = 10'h001;
    data_valid = 1'b1;
    tick();                                    // edge k: accepted
    data_valid = 1'b0;
    chk_b("single_ready_c0", data_ready, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c >= 2) chk_r($sformatf("single_ffe[%0d]", c), ffe_out, exp_single[c-2]);
      if (c >= 2 && c <= 11) begin
        chk_b($sformatf("single_bit[%0d]", c), bit_out, (c == 2));
        chk_b($sformatf("single_act[%0d]", c), tx_active, 1'b1);
      end
    end
    chk_b("single_idle_act", tx_active, 1'b0);
    chk_b("single_idle_ready", data_ready, 1'b1);

    // ---- reset mid-word ---------------------------------------------------
    data_in    = 10'h3FF;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    tick();                                    // all three taps hold +1
    chk_r("midword_ffe", ffe_out, 0.4);
    #2 rst = 1'b1;
    #1;
    chk_r("midword_rst_ffe", ffe_out, 0.0);
    chk_b("midword_rst_ready", data_ready, 1'b0);
    chk_b("midword_rst_act", tx_active, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_b("post_rst_ready", data_ready, 1'b1);
    chk_b("post_rst_act", tx_active, 1'b0);
    tick();
    tick();
    chk_r("post_rst_no_resume", ffe_out, 0.0);

    // ---- back-to-back 10'h3FF then 10'h000 --------------------------------
    data_in    = 10'h3FF;
    data_valid = 1'b1;
    tick();                                    // edge k
    data_in = 10'h000;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) tick();
      if (c == 8) chk_b("b2b_ready_c8", data_ready, 1'b0);
      if (c == 9) chk_b("b2b_ready_c9", data_ready, 1'b1);
      if (c == 10) data_valid = 1'b0;
      if (c == 11) chk_r("b2b_last_one", ffe_out, 0.6);
      if (c == 12) chk_r("b2b_first_zero", ffe_out, -0.8);
      if (c >= 2) chk_b($sformatf("b2b_act[%0d]", c), tx_active, 1'b1);
    end
    for (int i = 0; i < 3; i++) tick();
    chk_r("b2b_drained", ffe_out, 0.0);

    // ---- alternating 10'h155 streamed continuously -------------------------
    data_in    = 10'h155;
    data_valid = 1'b1;
    tick();                                    // edge k
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 20) data_valid = 1'b0;          // third word taken at edge k+20
      if (c >= 3) chk_r($sformatf("alt_ffe[%0d]", c), ffe_out,
                        (((c - 2) % 2) == 0) ? 1.0 : -1.0);
    end
    for (int i = 0; i < 9; i++) tick();
    chk_r("alt_drained", ffe_out, 0.0);
    chk_b("alt_drained_act", tx_active, 1'b0);

    // ---- backpressure: second word held until cnt reaches the last bit -----
    stream     = {10'h1C7, 10'h2B4};
    data_in    = 10'h2B4;
    data_valid = 1'b1;
    tick();                                    // edge k: first word
    data_in = 10'h1C7;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) tick();
      if (c < 9) chk_b($sformatf("bp_ready[%0d]", c), data_ready, 1'b0);
      else if (c == 9) chk_b("bp_ready[9]", data_ready, 1'b1);
      if (c == 10) data_valid = 1'b0;
      if (c >= 2) begin
        chk_b($sformatf("bp_bit[%0d]", c), bit_out, stream[c-2]);
        chk_b($sformatf("bp_act[%0d]", c), tx_active, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) tick();
    chk_r("bp_drained", ffe_out, 0.0);

    // ---- main-tap-only instance, half swing --------------------------------
    chk_r("sweep_idle_ffe", ffe_out2, 0.0);
    word        = 10'h0F3;
    data_in2    = word;
    data_valid2 = 1'b1;
    tick();                                    // edge k
    data_valid2 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c >= 2 && c <= 11) begin
        chk_r($sformatf("sweep_ffe[%0d]", c), ffe_out2, word[c-2] ? 0.35 : -0.35);
        chk_b($sformatf("sweep_bit[%0d]", c), bit_out2, word[c-2]);
      end
    end
    chk_r("sweep_tail_ffe", ffe_out2, 0.0);
    chk_b("sweep_tail_act", tx_active2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
